// File: rtl/decode_stage_pipelined_if.sv
// Handshake bundles around the decode stage: the IF -> ID instruction stream
// and the registered ID/EX entry presented to EXE.
interface decode_stage_pipelined_in_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;

   modport master (output in_valid, output instr, input in_ready);
   modport slave  (input in_valid, input instr, output in_ready);
endinterface

interface decode_stage_pipelined_out_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              out_valid;
   logic              out_ready;
   logic              out_wb_en;
   logic              out_mem_r_en;
   logic              out_mem_w_en;
   logic              out_b;
   logic              out_s;
   logic [3:0]        out_exe_cmd;
   logic [DATA_W-1:0] out_val_rn;
   logic [DATA_W-1:0] out_val_rm;
   logic              out_imm;
   logic [11:0]       out_shift_operand;
   logic [23:0]       out_signed_imm_24;
   logic [REG_AW-1:0] out_dest;

   modport master (
      output out_valid, out_wb_en, out_mem_r_en, out_mem_w_en, out_b, out_s,
             out_exe_cmd, out_val_rn, out_val_rm, out_imm, out_shift_operand,
             out_signed_imm_24, out_dest,
      input  out_ready
   );
   modport slave (
      input  out_valid, out_wb_en, out_mem_r_en, out_mem_w_en, out_b, out_s,
             out_exe_cmd, out_val_rn, out_val_rm, out_imm, out_shift_operand,
             out_signed_imm_24, out_dest,
      output out_ready
   );
endinterface

// File: rtl/decode_stage_pipelined.sv
// ARM-subset decode stage: decode, condition check, register file with
// writeback bypass, and a built-in ID/EX register with valid/ready handshakes.
module decode_stage_pipelined #(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 4,
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   decode_stage_pipelined_in_if.slave   up,
   decode_stage_pipelined_out_if.master dn,
   input  logic                         wb_en,
   input  logic [REG_AW-1:0]            wb_dest,
   input  logic [DATA_W-1:0]            wb_value,
   input  logic                         hazard,
   input  logic                         flush,
   input  logic [3:0]                   sr,
   output logic [REG_AW-1:0]            src1,
   output logic [REG_AW-1:0]            src2,
   output logic                         two_src
);
   localparam int NREG = 2 ** REG_AW;

   typedef enum logic [1:0] {
      MODE_DP  = 2'b00,
      MODE_MEM = 2'b01,
      MODE_BR  = 2'b10,
      MODE_CO  = 2'b11
   } mode_e;

   typedef struct packed {
      logic       wb_en;
      logic       mem_r_en;
      logic       mem_w_en;
      logic       b;
      logic       s;
      logic [3:0] exe_cmd;
   } ctrl_t;

   mode_e             mode;
   logic [3:0]        opcode;
   logic              is_str;
   ctrl_t             dec_ctrl;
   ctrl_t             ctrl_d;
   logic              load;
   logic [DATA_W-1:0] val_rn_d;
   logic [DATA_W-1:0] val_rm_d;
   logic [DATA_W-1:0] rf_q [NREG];

   logic              valid_q;
   ctrl_t             ctrl_q;
   logic [DATA_W-1:0] val_rn_q;
   logic [DATA_W-1:0] val_rm_q;
   logic              imm_q;
   logic [11:0]       shift_q;
   logic [23:0]       simm_q;
   logic [REG_AW-1:0] dest_q;

   assign mode    = mode_e'(up.instr[27:26]);
   assign opcode  = up.instr[24:21];
   assign is_str  = (mode == MODE_MEM) && !up.instr[20];
   assign src1    = REG_AW'(up.instr[19:16]);
   assign src2    = is_str ? REG_AW'(up.instr[15:12]) : REG_AW'(up.instr[3:0]);
   assign two_src = ~up.instr[25] | is_str;

   function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      {n, z, c, v} = flags;
      case (cond)
         4'h0:    return z;
         4'h1:    return ~z;
         4'h2:    return c;
         4'h3:    return ~c;
         4'h4:    return n;
         4'h5:    return ~n;
         4'h6:    return v;
         4'h7:    return ~v;
         4'h8:    return c & ~z;
         4'h9:    return ~c | z;
         4'hA:    return n == v;
         4'hB:    return n != v;
         4'hC:    return ~z & (n == v);
         4'hD:    return z | (n != v);
         4'hE:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      // NOTE: every field gets a default before the case so no path leaves
      // dec_ctrl unassigned, which would otherwise infer a latch.
      dec_ctrl = '0;
      case (mode)
         MODE_DP: begin
            dec_ctrl.s     = up.instr[20];
            dec_ctrl.wb_en = 1'b1;
            case (opcode)
               4'b1101: dec_ctrl.exe_cmd = 4'b0001;
               4'b1111: dec_ctrl.exe_cmd = 4'b1001;
               4'b0100: dec_ctrl.exe_cmd = 4'b0010;
               4'b0101: dec_ctrl.exe_cmd = 4'b0011;
               4'b0010: dec_ctrl.exe_cmd = 4'b0100;
               4'b0110: dec_ctrl.exe_cmd = 4'b0101;
               4'b0000: dec_ctrl.exe_cmd = 4'b0110;
               4'b1100: dec_ctrl.exe_cmd = 4'b0111;
               4'b0001: dec_ctrl.exe_cmd = 4'b1000;
               4'b1010: begin
                  dec_ctrl.exe_cmd = 4'b0100;
                  dec_ctrl.wb_en   = 1'b0;
               end
               4'b1000: begin
                  dec_ctrl.exe_cmd = 4'b0110;
                  dec_ctrl.wb_en   = 1'b0;
               end
               default: dec_ctrl = '0;
            endcase
         end
         MODE_MEM: begin
            dec_ctrl.exe_cmd = 4'b0010;
            if (up.instr[20]) begin
               dec_ctrl.mem_r_en = 1'b1;
               dec_ctrl.wb_en    = 1'b1;
            end else begin
               dec_ctrl.mem_w_en = 1'b1;
            end
         end
         MODE_BR: dec_ctrl.b = 1'b1;
         default: dec_ctrl = '0;
      endcase
   end

   // A failed condition still produces a valid entry, just with no side effects.
   assign ctrl_d = cond_ok(up.instr[31:28], sr) ? dec_ctrl : '0;

   always_comb begin
      val_rn_d = rf_q[src1];
      val_rm_d = rf_q[src2];
      if (BYPASS_EN && wb_en && (wb_dest == src1)) val_rn_d = wb_value;
      if (BYPASS_EN && wb_en && (wb_dest == src2)) val_rm_d = wb_value;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the register file is cleared entry by entry on reset so every
         // architectural register reads zero afterwards, unlike a plain RAM.
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wb_en) begin
         rf_q[wb_dest] <= wb_value;
      end
   end

   assign load        = dn.out_ready | ~valid_q;
   assign up.in_ready = load & ~hazard;

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state updates use <= so every register samples pre-edge values.
      if (!reset) begin
         valid_q  <= 1'b0;
         ctrl_q   <= '0;
         val_rn_q <= '0;
         val_rm_q <= '0;
         imm_q    <= 1'b0;
         shift_q  <= '0;
         simm_q   <= '0;
         dest_q   <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (load) begin
         if (hazard) begin
            valid_q <= 1'b1;
            ctrl_q  <= '0;
         end else if (!up.in_valid) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
         end else begin
            valid_q  <= 1'b1;
            ctrl_q   <= ctrl_d;
            val_rn_q <= val_rn_d;
            val_rm_q <= val_rm_d;
            imm_q    <= up.instr[25];
            shift_q  <= up.instr[11:0];
            simm_q   <= up.instr[23:0];
            dest_q   <= REG_AW'(up.instr[15:12]);
         end
      end
   end

   assign dn.out_valid         = valid_q;
   assign dn.out_wb_en         = ctrl_q.wb_en;
   assign dn.out_mem_r_en      = ctrl_q.mem_r_en;
   assign dn.out_mem_w_en      = ctrl_q.mem_w_en;
   assign dn.out_b             = ctrl_q.b;
   assign dn.out_s             = ctrl_q.s;
   assign dn.out_exe_cmd       = ctrl_q.exe_cmd;
   assign dn.out_val_rn        = val_rn_q;
   assign dn.out_val_rm        = val_rm_q;
   assign dn.out_imm           = imm_q;
   assign dn.out_shift_operand = shift_q;
   assign dn.out_signed_imm_24 = simm_q;
   assign dn.out_dest          = dest_q;
endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
Parametrised ARM-subset decode stage with its own registered ID/EX output, so a separate ID/EX register is not needed. It combines instruction decode, condition check, a register file with writeback bypass, hazard-source reporting, and valid/ready handshakes on both sides. It sits between the IF stage (upstream) and the EXE stage (downstream). Hazard stalls, flushes and downstream backpressure are handled cycle-accurately inside the block.

Parameters:
DATA_W, 32, width of register-file entries and of Val_Rn/Val_Rm.
REG_AW, 4, register address width; the register file holds 2**REG_AW entries.
BYPASS_EN, 1, 1 = a same-cycle writeback is forwarded to the read ports; 0 = the read returns the old value.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  IF presents an instruction.
in_ready  out  1  stage accepts the instruction this cycle.
instr  in  32  instruction word.
wb_en  in  1  writeback enable.
wb_dest  in  REG_AW  writeback register.
wb_value  in  DATA_W  writeback data.
hazard  in  1  hazard unit requests a stall of the current instruction.
flush  in  1  taken branch; kill the held output and the incoming instruction.
sr  in  4  status {N,Z,C,V}.
src1  out  REG_AW  combinational: instr[19:16] truncated/extended to REG_AW.
src2  out  REG_AW  combinational: instr[15:12] if STR, else instr[3:0].
two_src  out  1  combinational: ~instr[25] | STR.
out_valid  out  1  registered ID/EX entry is valid.
out_ready  in  1  EXE consumes the entry.
out_wb_en, out_mem_r_en, out_mem_w_en, out_b, out_s  out  1 each  control.
out_exe_cmd  out  4  ALU command.
out_val_rn, out_val_rm  out  DATA_W  operands.
out_imm  out  1  instr[25].
out_shift_operand  out  12  instr[11:0].
out_signed_imm_24  out  24  instr[23:0].
out_dest  out  REG_AW  instr[15:12].

Behaviour:
- One clock; reset is asynchronous and active-low.
- While reset=0: all out_* = 0, out_valid = 0, all register-file entries = 0.
- Register file:
  - Write at rising edge when wb_en=1.
  - Reads are combinational, for src1 and src2.
  - With BYPASS_EN=1, wb_en and wb_dest matching a read address returns wb_value in the same cycle.
- Decode, mode = instr[27:26], opcode = instr[24:21]:
  - Mode 00, data processing: MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110.
  - wb_en = 1 for all listed opcodes except CMP and TST.
  - s = instr[20].
  - Unlisted opcode: all control bits 0.
  - Mode 01, memory: exe_cmd 0010. instr[20]=1 → LDR (mem_r_en=1, wb_en=1); else STR (mem_w_en=1). s = 0.
  - Mode 10: b = 1, all other control bits 0.
  - Mode 11: all control bits 0.
- Condition check: standard ARM codes 0000–1110 evaluated on sr; 1111 is treated as never. A failed condition zeroes all control bits but out_valid still goes to 1 (bubble carrying data fields).
- Handshake:
  - load = out_ready | ~out_valid.
  - in_ready = load & ~hazard.
  - On a rising edge with load=1:
    - flush=1 → out_valid ← 0, control ← 0.
    - else hazard=1 or in_valid=0 → out_valid ← 1 with control bits 0 if hazard=1 (bubble); out_valid ← 0 if in_valid=0 and hazard=0.
    - else capture the decoded instruction, out_valid ← 1.
  - On a rising edge with load=0 (backpressure): all out_* hold. Exception: flush=1 still clears out_valid and control.
- Latency: instruction accepted at edge N is visible on out_* after edge N.
- Simultaneous events:
  - Writeback to a source register in the same cycle as capture is taken only via bypass (BYPASS_EN=1). With BYPASS_EN=0 the captured value is the pre-write value.
  - flush takes priority over hazard and in_valid.
- Reset asserted mid-stall drops the held entry immediately (asynchronous).

Test Plan:
- Reset, then instr=0xE3A01005 (MOV R1,#5, AL), in_valid=1, out_ready=1 → next cycle: out_valid=1, out_exe_cmd=0001, out_wb_en=1, out_imm=1, out_dest=1, out_shift_operand=0x005.
- wb_en=1, wb_dest=2, wb_value=0x1234 in the same cycle as ADD R3,R2,R2 (0xE0823002) with BYPASS_EN=1 → out_val_rn=out_val_rm=0x1234. With BYPASS_EN=0 → both 0.
- hazard=1 for 2 cycles holding STR R4,[R5] (0xE5854000) → in_ready=0 and bubbles (control=0, out_valid=1) for 2 cycles. Then capture with out_mem_w_en=1, src2=4, two_src=1.
- Instr 0x03A01001 (MOVEQ) with sr=0000 → control all 0. Same instr with sr=0100 → out_wb_en=1.
- out_ready=0 for 3 cycles after capture → out_* stable and in_ready=0. flush=1 on the 2nd of those cycles → out_valid=0 on the next cycle.
- reset asserted asynchronously mid-cycle while out_valid=1 → out_valid=0 immediately, without waiting for a clock edge.
